// File: rtl/ws_log_pkg.sv
// Shared FSM state encoding and payload byte offsets for the jitter aggregator.
package ws_log_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_t;

  localparam int CNT_OFF = 0;
  localparam int JTR_OFF = 4;

  function automatic int drop_off(input int nch);
    return JTR_OFF + 2 * nch;
  endfunction
endpackage

// File: rtl/ws_abs_diff.sv
// Absolute value of the signed modular difference a-b; -2^(NM-1) maps to 2^(NM-1).
module ws_abs_diff #(
  parameter int NM = 16
) (
  input  logic [NM-1:0] a,
  input  logic [NM-1:0] b,
  output logic [NM-1:0] d
);
  logic [NM-1:0] diff;

  assign diff = a - b;
  assign d    = diff[NM-1] ? ('0 - diff) : diff;
endmodule

// File: rtl/ws_jitter_agg.sv
// Per-channel worst-case jitter aggregator; frames every 2^NPR measurements or on limit excess.
// Optional WS_LOG_DROP_CNT_EN adds a saturating 16-bit drop counter to the payload.
module ws_jitter_agg
  import ws_log_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int NM   = 16,
  parameter int NPR  = 7,
  parameter int NL   = 8,
  parameter int P_SZ = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_rdy,
  input  logic [31:0]       p_cnt,
  input  logic [NM-1:0]     tr,
  input  logic [NCH*NM-1:0] ts,
  input  logic [NCH-1:0]    ts_vld,
  input  logic [6:0]        addr,
  output logic [7:0]        payload,
  output logic              start,
  input  logic              tx_done,
  output logic              busy,
  output logic [NCH*NM-1:0] jtr
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NM-1:0] LIMIT = NM'((1 << (NM - NL)) - 1);
  localparam int DROP_OFF = drop_off(NCH);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [NM-1:0]       tr_q;
  logic [NCH*NM-1:0]   ts_q;
  logic [NCH-1:0]      vld_q;
  logic [31:0]         pcnt_q;
  logic [NCH*NM-1:0]   cur_max;
  logic                exceed_q;
  logic [31:0]         count_q;
  logic                load, decide;
  logic [NM-1:0]       ts_sel, cm_sel, ad, d;
  logic                trigger, busy_eff;
  logic [15:0]         drop_val;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    decide  = 1'b0;
    case (state_q)
      S_IDLE: if (st_rdy) begin
        load    = 1'b1;
        state_d = S_SCAN;
      end
      S_SCAN: if (idx_q == IW'(NCH - 1)) state_d = S_DECIDE;
      S_DECIDE: begin
        decide  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign ts_sel = ts_q[idx_q*NM +: NM];
  assign cm_sel = cur_max[idx_q*NM +: NM];

  ws_abs_diff #(.NM(NM)) u_diff (.a(ts_sel), .b(tr_q), .d(ad));

  assign d        = vld_q[idx_q] ? ad : '1;
  assign trigger  = exceed_q | (&pcnt_q[NPR-1:0]);
  // A sender completing in the same cycle frees the slot for this frame.
  assign busy_eff = busy & ~tx_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      tr_q     <= '0;
      ts_q     <= '0;
      vld_q    <= '0;
      pcnt_q   <= '0;
      cur_max  <= '0;
      exceed_q <= 1'b0;
      count_q  <= '0;
      jtr      <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start <= 1'b0;
      if (tx_done) busy <= 1'b0;
      if (load) begin
        tr_q   <= tr;
        ts_q   <= ts;
        vld_q  <= ts_vld;
        pcnt_q <= p_cnt;
        idx_q  <= '0;
      end
      if (state_q == S_SCAN) begin
        idx_q <= idx_q + IW'(1);
        if (d > cm_sel) cur_max[idx_q*NM +: NM] <= d;
        if (d > LIMIT) exceed_q <= 1'b1;
      end
      if (decide) begin
        exceed_q <= 1'b0;
        if (trigger && !busy_eff) begin
          jtr     <= cur_max;
          count_q <= pcnt_q;
          cur_max <= '0;
          start   <= 1'b1;
          busy    <= 1'b1;
        end
      end
    end
  end

`ifdef WS_LOG_DROP_CNT_EN
  logic        st_drop, dec_drop;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt;

  assign st_drop  = st_rdy && (state_q != S_IDLE);
  assign dec_drop = decide && trigger && busy_eff;
  assign drop_inc = {1'b0, st_drop} + {1'b0, dec_drop};
  assign drop_sum = {1'b0, drop_cnt} + {15'b0, drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign drop_val = drop_cnt;
`else
  assign drop_val = '0;
`endif

  always_comb begin
    int a;
    logic [15:0] jv;
    a       = int'(addr);
    jv      = '0;
    payload = '0;
    if (a < P_SZ) begin
      for (int b = 0; b < 4; b++)
        if (a == CNT_OFF + b) payload = count_q[8*b +: 8];
      for (int i = 0; i < NCH; i++) begin
        jv = 16'(jtr[i*NM +: NM]);
        if (a == JTR_OFF + 2*i)     payload = jv[7:0];
        if (a == JTR_OFF + 2*i + 1) payload = jv[15:8];
      end
      if (a == DROP_OFF)     payload = drop_val[7:0];
      if (a == DROP_OFF + 1) payload = drop_val[15:8];
    end
  end
endmodule

// File: doc/ws_jitter_agg.md
WS_JITTER_AGG -- requirements
Module: ws_jitter_agg

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of slave channels.
REQ-002 SHALL have parameter NM, default 16, the timestamp and jitter width.
REQ-003 SHALL have parameter NPR, default 7; a frame is sent every 2^NPR measurements.
REQ-004 SHALL have parameter NL, default 8; the jitter limit is 2^(NM-NL)-1.
REQ-005 SHALL have parameter P_SZ, default 18, the payload size in bytes, with P_SZ >= 4+2*NCH+2.
REQ-006 SHALL have the following ports, one per line:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- st_rdy  in  1  one-cycle strobe marking end of measurement.
- p_cnt  in  32  measurement counter.
- tr  in  NM  trigger-channel timestamp.
- ts  in  NCH*NM  slave timestamps; channel i is at [i*NM +: NM].
- ts_vld  in  NCH  per-channel flag: an edge was seen in this measurement.
- addr  in  7  payload byte index.
- payload  out  8  payload byte at addr (combinational read).
- start  out  1  one-cycle pulse to the UDP sender.
- tx_done  in  1  one-cycle pulse: sender finished the frame.
- busy  out  1  a frame is in flight.
- jtr  out  NCH*NM  snapshot of per-channel worst-case jitter.

Function
REQ-007 SHALL implement FSM IDLE->SCAN->DECIDE->IDLE.
REQ-008 In IDLE, on st_rdy, SHALL latch tr, ts, ts_vld and p_cnt, then enter SCAN.
REQ-009 SCAN SHALL process one channel per cycle, i=0..NCH-1, using a single shared difference unit.
REQ-010 Per-channel jitter d:
- if ts_vld[i]=1: d = |(ts_i - tr) mod 2^NM|, with the difference taken as signed NM bits; the result is unsigned NM bits, so -2^(NM-1) gives 2^(NM-1).
- if ts_vld[i]=0: d = all-ones.
REQ-011 SCAN SHALL update cur_max_i <= max(cur_max_i, d).
REQ-012 SCAN SHALL set an exceed flag if any d > 2^(NM-NL)-1.
REQ-013 DECIDE SHALL trigger when exceed=1 or p_cnt_latched[NPR-1:0] is all ones.
REQ-014 On a trigger with busy=0, SHALL:
- copy cur_max to jtr and p_cnt_latched to the payload count;
- clear cur_max and exceed;
- pulse start;
- set busy.
REQ-015 On a trigger with busy=1, SHALL emit no start, SHALL leave jtr unchanged, SHALL retain cur_max, and SHALL increment drop_cnt.
REQ-016 With no trigger, SHALL clear exceed and return to IDLE.
REQ-017 Latency from st_rdy (cycle 0) to start SHALL be NCH+2 cycles.
REQ-018 If st_rdy arrives outside IDLE, SHALL ignore it and increment drop_cnt.
REQ-019 tx_done SHALL clear busy; when tx_done and a trigger fall in the same cycle, tx_done SHALL win and the frame SHALL start.
REQ-020 Payload layout, little-endian:
- bytes 0-3: count;
- bytes 4+2i and 5+2i: jtr_i;
- bytes 4+2*NCH and 5+2*NCH: drop_cnt;
- all remaining bytes, including addr >= P_SZ, read as 0.
REQ-021 drop_cnt SHALL be 16 bits, saturating at FFFF, and SHALL NOT clear on send.

Reset
REQ-022 rst=0 SHALL asynchronously force:
- state IDLE;
- start=0 and busy=0;
- jtr, cur_max, count and drop_cnt to 0;
- exceed=0.
REQ-023 Reset mid-SCAN or while busy SHALL abandon the operation; no start SHALL follow reset release without a new st_rdy.

Configuration
REQ-024 With WS_LOG_DROP_CNT_EN defined, SHALL implement drop_cnt as specified.
REQ-025 Without WS_LOG_DROP_CNT_EN, drop_cnt logic SHALL be absent, its payload bytes SHALL read 0, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package ws_log_pkg SHALL hold the FSM state enum and the payload offset constants (count, jitter base, drop).
REQ-027 The signed-modular absolute difference SHALL be sub-module ws_abs_diff (parameter NM).

Verification
REQ-028 Reset: hold rst=0 mid-SCAN -> start=0, busy=0, all payload bytes 00; no start after release.
REQ-029 tr=1000, ts={1003,998,1000,1010}, all valid, p_cnt=127 -> start at cycle 6; bytes 0-11 = 7F 00 00 00 03 00 02 00 00 00 0A 00.
REQ-030 p_cnt=5, ts1=tr+256 -> start (exceed). Repeat with ts1=tr+255 -> no start, cur_max1=255 retained.
REQ-031 Wrap: tr=FFF0, ts0=0005, p_cnt=127 -> jtr0=0015. Missing edge: ts_vld[2]=0 -> jtr2=FFFF plus immediate start.
REQ-032 Busy drop: trigger with busy=1 -> no start, drop_cnt=1 (bytes 12-13 = 01 00 with the macro, 00 00 without); the next frame carries the retained max.
REQ-033 tx_done coincident with a DECIDE trigger -> start is issued the same cycle and busy stays 1.
